// File: rtl/cpu_pkg.sv
// Shared types and default widths for the register-file datapath:
// opcodes, execute-stage FSM states and the W/A defaults.
package cpu_pkg;

    localparam int W_DEF = 8;
    localparam int A_DEF = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        WB    = 2'd3
    } state_t;

endpackage

// File: rtl/iter_unit.sv
// Multi-cycle datapath for the execute stage: 1-bit-per-cycle shifter and
// W-iteration shift-add multiplier sharing one down-counter.
module iter_unit
    import cpu_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int SH_W  = $clog2(W);

    logic [CNT_W-1:0] cnt;
    logic             is_mul;
    logic             left;
    logic [W-1:0]     sreg;
    logic [W-1:0]     mcand;
    logic [2*W-1:0]   prod;

    logic [W-1:0]     sreg_nx;
    logic             shift_c;
    logic [W:0]       sum;
    logic [2*W-1:0]   prod_nx;

    // prod holds {partial product, remaining multiplier bits}; each step adds
    // the multiplicand to the upper half when the current multiplier LSB is set.
    always_comb begin
        sum     = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : {W{1'b0}})};
        prod_nx = {sum, prod[W-1:1]};
        if (left) begin
            sreg_nx = {sreg[W-2:0], 1'b0};
            shift_c = sreg[W-1];
        end else begin
            sreg_nx = {1'b0, sreg[W-1:1]};
            shift_c = sreg[0];
        end
    end

    // done marks the final step; result/carry are that step's outcome so the
    // caller can capture them on the same edge.
    assign done   = (cnt == CNT_W'(1));
    assign result = is_mul ? prod_nx[W-1:0] : sreg_nx;
    assign carry  = is_mul ? (prod_nx[2*W-1:W] != {W{1'b0}}) : shift_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_mul <= 1'b0;
            left   <= 1'b0;
            sreg   <= '0;
            mcand  <= '0;
            prod   <= '0;
        end else if (start) begin
            is_mul <= (op == OP_MUL);
            left   <= (op == OP_SHL);
            cnt    <= (op == OP_MUL) ? CNT_W'(W) : CNT_W'(b[SH_W-1:0]);
            sreg   <= a;
            mcand  <= a;
            prod   <= {{W{1'b0}}, b};
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            sreg <= sreg_nx;
            prod <= prod_nx;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// 8-bit execute stage: accepts one op per handshake, computes via the
// single-cycle ALU or iter_unit, and emits a one-cycle register write-back.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         InValid,
    output logic         InReady,
    input  op_t          Op,
    input  logic [W-1:0] OperandA,
    input  logic [W-1:0] OperandB,
    input  logic [A-1:0] Dest,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         Carry,
    output logic         Zero,
    output logic         Busy,
    output state_t       DbgState
);

    localparam int SH_W = $clog2(W);

    state_t       state_q;
    state_t       state_d;
    logic         accept;
    logic         iter_start;
    logic         iter_done;
    logic         iter_carry;
    logic [W-1:0] iter_result;
    logic         shift_nonzero;
    logic [W:0]   wide;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         pend_c;
    logic [A-1:0] dest_q;

    // Handshake: a transfer happens on the rising edge where InValid && InReady.
    // InReady is decoded from state only; upstream holds InValid and payload
    // stable until that edge, and payload is ignored after it.
    assign InReady  = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);
    assign WriteEn  = (state_q == WB);
    assign DbgState = state_q;
    assign accept   = InValid && InReady;

    assign shift_nonzero = ((Op == OP_SHL) || (Op == OP_SHR)) &&
                           (OperandB[SH_W-1:0] != '0);

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (Op)
            OP_ADD: begin
                wide    = {1'b0, OperandA} + {1'b0, OperandB};
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
            end
            OP_SUB: begin
                wide    = {1'b0, OperandA} - {1'b0, OperandB};
                alu_res = wide[W-1:0];
                alu_c   = ~wide[W];
            end
            OP_AND: alu_res = OperandA & OperandB;
            OP_OR:  alu_res = OperandA | OperandB;
            OP_XOR: alu_res = OperandA ^ OperandB;
            // Only zero-count shifts reach the single-cycle path.
            OP_SHL, OP_SHR: alu_res = OperandA;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        iter_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (Op == OP_MUL) begin
                        state_d    = MUL;
                        iter_start = 1'b1;
                    end else if (shift_nonzero) begin
                        state_d    = SHIFT;
                        iter_start = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            SHIFT, MUL: if (iter_done) state_d = WB;
            WB:         state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dest_q <= '0;
            DataIn <= '0;
            Waddr  <= '0;
            pend_c <= 1'b0;
            Carry  <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            if (accept) dest_q <= Dest;
            if (accept && (state_d == WB)) begin
                DataIn <= alu_res;
                Waddr  <= Dest;
                pend_c <= alu_c;
            end else if (((state_q == SHIFT) || (state_q == MUL)) && iter_done) begin
                DataIn <= iter_result;
                Waddr  <= dest_q;
                pend_c <= iter_carry;
            end
            // Flags commit on the edge leaving WB, from the result being written.
            if (state_q == WB) begin
                Carry <= pend_c;
                Zero  <= (DataIn == '0);
            end
        end
    end

    iter_unit #(.W(W)) u_iter (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .start  (iter_start),
        .op     (Op),
        .a      (OperandA),
        .b      (OperandB),
        .done   (iter_done),
        .result (iter_result),
        .carry  (iter_carry)
    );

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: scenario tasks with a scoreboard queue
// of expected {addr, data, carry, zero} write-backs.
module tb_exec_unit;
    import cpu_pkg::*;

    localparam int W  = 8;
    localparam int A  = 2;
    localparam int EW = A + W + 2;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         InValid;
    logic         InReady;
    op_t          Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic [A-1:0] Dest;
    logic         WriteEn;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic         Carry;
    logic         Zero;
    logic         Busy;
    state_t       DbgState;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    exec_unit #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .Op(Op), .OperandA(OperandA), .OperandB(OperandB), .Dest(Dest),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .Carry(Carry),
        .Zero(Zero), .Busy(Busy), .DbgState(DbgState)
    );

    function automatic logic [EW-1:0] model(op_t op, logic [W-1:0] a, logic [W-1:0] b,
                                            logic [A-1:0] d);
        logic [2*W-1:0] t;
        logic [W-1:0]   r;
        logic           c;
        int             n;
        n = int'(b[2:0]);
        t = '0;
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin t = {8'h00, a} + {8'h00, b}; r = t[W-1:0]; c = t[W]; end
            OP_SUB: begin r = a - b; c = (a >= b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin t = {8'h00, a} << n; r = t[W-1:0]; c = (n != 0) && t[W]; end
            OP_SHR: begin t = {a, 8'h00} >> n; r = t[2*W-1:W]; c = (n != 0) && t[W-1]; end
            default: begin t = {8'h00, a} * {8'h00, b}; r = t[W-1:0]; c = (t[2*W-1:W] != 0); end
        endcase
        return {d, r, c, (r == 0)};
    endfunction

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!InReady && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (!InReady) begin
            errors++;
            $display("FAIL %s ready_timeout InReady=%0b required=1", name, InReady);
        end
    endtask

    task automatic issue(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [A-1:0] d, input string name);
        int lat, exp_lat, busy_bad;
        logic [EW-1:0] e;
        wait_ready(name);
        InValid = 1'b1; Op = op; OperandA = a; OperandB = b; Dest = d;
        exp_q.push_back(model(op, a, b, d));
        exp_lat = (op == OP_MUL) ? W + 1 :
                  ((op == OP_SHL) || (op == OP_SHR)) ? int'(b[2:0]) + 1 : 1;
        @(negedge Clk);
        InValid = 1'b0;
        OperandA = W'($urandom); OperandB = W'($urandom); Dest = A'($urandom);
        Op = op_t'($urandom_range(0, 7));
        lat = 1;
        busy_bad = 0;
        while (!WriteEn && lat < 20) begin
            if (InReady) busy_bad++;
            @(negedge Clk);
            lat++;
        end
        if (InReady) busy_bad++;
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s inready_busy got=%0d high cycles exp=0", name, busy_bad);
        end
        e = exp_q.pop_front();
        if (WriteEn) begin
            checks++;
            if ({Waddr, DataIn} !== e[EW-1:2]) begin
                errors++;
                $display("FAIL %s wb got addr=%0d data=%h exp addr=%0d data=%h",
                         name, Waddr, DataIn, e[EW-1:EW-A], e[W+1:2]);
            end
            @(negedge Clk);
            checks++;
            if ({Carry, Zero} !== e[1:0]) begin
                errors++;
                $display("FAIL %s flags got C=%0b Z=%0b exp C=%0b Z=%0b",
                         name, Carry, Zero, e[1], e[0]);
            end
            checks++;
            if (WriteEn !== 1'b0 || InReady !== 1'b1) begin
                errors++;
                $display("FAIL %s after_wb got we=%0b rdy=%0b exp we=0 rdy=1",
                         name, WriteEn, InReady);
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; InValid = 1'b0; Op = OP_ADD;
        OperandA = '0; OperandB = '0; Dest = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({WriteEn, Waddr, DataIn, Carry, Zero, Busy, InReady} !== {1'b0, 2'd0, 8'h00, 4'b0001}) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b wa=%0d di=%h c=%0b z=%0b busy=%0b rdy=%0b exp 0/0/00/0/0/0/1",
                     WriteEn, Waddr, DataIn, Carry, Zero, Busy, InReady);
        end
        checks++;
        if (DbgState !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", DbgState, IDLE);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_alu();
        issue(OP_ADD, 8'hFF, 8'h01, 2'd2, "add_wrap");
        issue(OP_SUB, 8'h05, 8'h07, 2'd1, "sub_borrow");
        issue(OP_SUB, 8'h07, 8'h05, 2'd3, "sub_noborrow");
        issue(OP_AND, 8'hF0, 8'h3C, 2'd0, "and");
        issue(OP_OR,  8'h00, 8'h00, 2'd1, "or_zero");
        issue(OP_XOR, 8'hA5, 8'h0F, 2'd2, "xor");
    endtask

    task automatic test_shift();
        issue(OP_SHL, 8'h81, 8'h03, 2'd1, "shl3");
        issue(OP_SHR, 8'h81, 8'h01, 2'd2, "shr1");
        issue(OP_SHL, 8'h5A, 8'hF8, 2'd3, "shl0");
        issue(OP_SHR, 8'h80, 8'h07, 2'd0, "shr7");
        issue(OP_SHL, 8'hFF, 8'h07, 2'd1, "shl7");
    endtask

    task automatic test_mul();
        issue(OP_MUL, 8'h10, 8'h11, 2'd1, "mul_ovf");
        issue(OP_MUL, 8'h03, 8'h05, 2'd2, "mul_small");
        issue(OP_MUL, 8'hFF, 8'hFF, 2'd3, "mul_max");
        issue(OP_MUL, 8'h00, 8'h9C, 2'd0, "mul_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            issue(op_t'($urandom_range(0, 7)), W'($urandom_range(0, 255)),
                  W'($urandom_range(0, 255)), A'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        int we_cnt, acc_cyc, order_bad;
        logic [EW-1:0] e;
        we_cnt = 0; acc_cyc = -1; order_bad = 0;
        wait_ready("b2b");
        InValid = 1'b1; Op = OP_MUL; OperandA = 8'h10; OperandB = 8'h11; Dest = 2'd3;
        exp_q.push_back(model(OP_MUL, 8'h10, 8'h11, 2'd3));
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge Clk);
            if (WriteEn) begin
                we_cnt++;
                if (exp_q.size() == 0) order_bad++;
                else begin
                    e = exp_q.pop_front();
                    if ({Waddr, DataIn} !== e[EW-1:2]) order_bad++;
                end
            end
            if (cyc == 1) begin
                Op = OP_ADD; OperandA = 8'h80; OperandB = 8'h80; Dest = 2'd1;
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) InValid = 1'b0;
            if (InValid && InReady && acc_cyc < 0) begin
                acc_cyc = cyc;
                exp_q.push_back(model(OP_ADD, 8'h80, 8'h80, 2'd1));
            end
        end
        InValid = 1'b0;
        checks++;
        if (acc_cyc !== 10) begin
            errors++;
            $display("FAIL b2b accept_cycle got=%0d exp=10", acc_cyc);
        end
        checks++;
        if (we_cnt !== 2 || order_bad !== 0) begin
            errors++;
            $display("FAIL b2b writebacks got count=%0d bad=%0d exp count=2 bad=0", we_cnt, order_bad);
        end
        checks++;
        if ({Carry, Zero} !== 2'b11) begin
            errors++;
            $display("FAIL b2b flags got C=%0b Z=%0b exp C=1 Z=1", Carry, Zero);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_mul();
        int we_cnt;
        wait_ready("rst_mul");
        InValid = 1'b1; Op = OP_MUL; OperandA = 8'hFF; OperandB = 8'h03; Dest = 2'd2;
        repeat (4) begin
            @(negedge Clk);
            InValid = 1'b0;
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Busy, InReady, WriteEn, Waddr, DataIn, Carry, Zero} !== {1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL rst_mul async got busy=%0b rdy=%0b we=%0b wa=%0d di=%h c=%0b z=%0b exp 0/1/0/0/00/0/0",
                     Busy, InReady, WriteEn, Waddr, DataIn, Carry, Zero);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        we_cnt = 0;
        repeat (15) begin
            @(negedge Clk);
            if (WriteEn) we_cnt++;
        end
        checks++;
        if (we_cnt !== 0 || {Carry, Zero} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mul after_release got we_pulses=%0d C=%0b Z=%0b exp 0/0/0",
                     we_cnt, Carry, Zero);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_mul();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        issue(OP_SUB, 8'h10, 8'h10, 2'd1, "post_reset_sub");
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
